// File: rtl/hamming_2d_scrub_ctrl.sv
// Purpose: arbitrate one ECC-protected codeword memory between host accesses and a background scrubber.
// Latency: host write completes in the grant cycle; host read returns 2 cycles after grant; scrub step 2-3 cycles.
// Backpressure: host_gnt drops while a scrub step runs or a starved scrub wins IDLE; the host holds host_req until granted.
module hamming_2d_scrub_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int STARVE_MAX     = 16,
  parameter int ERR_CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 clr_err,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [43:0]          host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [43:0]          host_rdata,
  output logic                 host_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [104:0]         mem_wdata,
  input  logic [104:0]         mem_rdata,
  output logic [43:0]          enc_data,
  input  logic [104:0]         enc_code,
  output logic [104:0]         dec_code,
  input  logic [43:0]          dec_data,
  input  logic                 dec_err,
  output logic                 busy,
  output logic                 sweep_done,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(SCRUB_INTERVAL + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  INT_LAST  = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [ST_W-1:0]   ST_LIMIT  = ST_W'(STARVE_MAX);

  typedef enum logic [2:0] {IDLE, HRD, SRD, SCHK, SWB} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  burst_q, burst_d;
  logic                  restart_q, restart_d;
  logic [ST_W-1:0]       starve_q, starve_d;
  logic [43:0]           data_q, data_d;
  logic                  rvalid_q, rvalid_d;
  logic [43:0]           rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;
  logic                  sdone_q, sdone_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;

  logic want_scrub;
  logic step_start;
  logic step_end;

  assign dec_code    = mem_rdata;
  assign busy        = (state_q != IDLE);
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
  assign host_err    = rerr_q;
  assign sweep_done  = sdone_q;
  assign err_count   = err_q;
  assign want_scrub  = pend_q | burst_q;

  // Arbitration, next state, memory/codec steering and bookkeeping updates.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    burst_d    = burst_q;
    restart_d  = restart_q;
    starve_d   = starve_q;
    data_d     = data_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    sdone_d    = 1'b0;
    err_d      = err_q;
    host_gnt   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = host_addr;
    mem_wdata  = enc_code;
    enc_data   = host_wdata;
    step_start = 1'b0;
    step_end   = 1'b0;

    case (state_q)
      IDLE: begin
        if (want_scrub && (starve_q >= ST_LIMIT)) begin
          step_start = 1'b1;
        end else if (host_req) begin
          host_gnt = 1'b1;
          mem_req  = 1'b1;
          mem_we   = host_we;
          if (want_scrub) starve_d = starve_q + ST_W'(1);
          if (!host_we) state_d = HRD;
        end else if (want_scrub) begin
          step_start = 1'b1;
        end
      end
      HRD: begin
        rvalid_d = 1'b1;
        rdata_d  = dec_data;
        rerr_d   = dec_err;
        state_d  = IDLE;
      end
      SRD: begin
        // Strobe here so the codeword is presented to the decoder in SCHK.
        mem_req  = 1'b1;
        mem_addr = addr_q;
        state_d  = SCHK;
      end
      SCHK: begin
        if (dec_err) begin
          data_d  = dec_data;
          state_d = SWB;
        end else begin
          step_end = 1'b1;
          state_d  = IDLE;
        end
      end
      SWB: begin
        enc_data = data_q;
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q;
        step_end = 1'b1;
        if (err_q != {ERR_CNT_W{1'b1}}) err_d = err_q + ERR_CNT_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (step_start) begin
      state_d   = SRD;
      starve_d  = '0;
      addr_d    = restart_q ? '0 : ptr_q;
      restart_d = 1'b0;
    end

    if (step_end) begin
      ptr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
      pend_d = 1'b0;
      if (addr_q == LAST_ADDR) begin
        sdone_d = 1'b1;
        burst_d = 1'b0;
      end
    end

    // A new interval tick outranks the clear from a step ending in the same cycle.
    if (!enable) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (!burst_q) begin
      if (cnt_q == INT_LAST) begin
        cnt_d  = '0;
        pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (start) begin
      burst_d   = 1'b1;
      restart_d = 1'b1;
    end

    if (clr_err) err_d = '0;
  end

  // State and bookkeeping registers; reset abandons any step in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      burst_q   <= 1'b0;
      restart_q <= 1'b0;
      starve_q  <= '0;
      data_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      sdone_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      burst_q   <= burst_d;
      restart_q <= restart_d;
      starve_q  <= starve_d;
      data_q    <= data_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      sdone_q   <= sdone_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_hamming_2d_scrub_ctrl.sv
// Bench for hamming_2d_scrub_ctrl: behavioural SEC codec, memory model with backdoor bit flips,
// scoreboard queues for read returns and scrub write-backs, directed scenarios.
module tb_hamming_2d_scrub_ctrl;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int SI     = 8;
  localparam int SM     = 16;
  localparam int EW     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0, start = 1'b0, clr_err = 1'b0;
  logic host_req = 1'b0, host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [43:0] host_wdata = '0;
  logic host_gnt, host_rvalid, host_err;
  logic [43:0] host_rdata;
  logic mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [104:0] mem_wdata, mem_rdata, enc_code, dec_code;
  logic [43:0] enc_data, dec_data;
  logic dec_err, busy, sweep_done;
  logic [EW-1:0] err_count;

  hamming_2d_scrub_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI),
                          .STARVE_MAX(SM), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .clr_err(clr_err),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .enc_data(enc_data), .enc_code(enc_code), .dec_code(dec_code),
    .dec_data(dec_data), .dec_err(dec_err), .busy(busy), .sweep_done(sweep_done),
    .err_count(err_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hamming SEC over positions 1..50: parity at powers of two, data elsewhere; other bits must be 0.
  function automatic logic [104:0] enc_f(input logic [43:0] d);
    logic [104:0] c;
    logic par;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p <= 50; p++)
      if ((p & (p - 1)) != 0) begin c[p] = d[j]; j++; end
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 50; p++)
        if (((p >> k) & 1) == 1) par = par ^ c[p];
      c[1 << k] = par;
    end
    return c;
  endfunction

  function automatic logic [44:0] dec_f(input logic [104:0] code);
    logic [104:0] c;
    logic [43:0] d;
    logic e;
    int s, j;
    c = code;
    s = 0;
    for (int p = 1; p <= 50; p++) if (c[p]) s = s ^ p;
    e = (s != 0) || c[0] || (c[104:51] != '0);
    if (s != 0 && s <= 50) c[s] = ~c[s];
    d = '0;
    j = 0;
    for (int p = 1; p <= 50; p++)
      if ((p & (p - 1)) != 0) begin d[j] = c[p]; j++; end
    return {e, d};
  endfunction

  assign enc_code = enc_f(enc_data);
  always_comb {dec_err, dec_data} = dec_f(dec_code);

  // Memory macro: one-cycle read latency, plus a backdoor bit-flip port.
  logic [104:0] mem [DEPTH];
  logic [104:0] rd_r;
  logic bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [104:0] bd_flip = '0;
  assign mem_rdata = rd_r;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rd_r = '0;
    forever begin
      @(posedge clk);
      if (mem_req && mem_we) mem[mem_addr] <= mem_wdata;
      else if (mem_req) rd_r <= mem[mem_addr];
      if (bd_we) mem[bd_addr] <= mem[bd_addr] ^ bd_flip;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out or unexpected event", name);
  endtask

  typedef struct packed { logic [43:0] d; logic e; int c; } rd_exp_t;
  typedef struct packed { logic [ADDR_W-1:0] a; logic [104:0] w; } wb_t;
  rd_exp_t rd_q[$];
  wb_t     wb_q[$];
  logic [ADDR_W-1:0] srd_addr[$];
  int      srd_cyc[$];
  int      sdone_cnt = 0;
  int      busy_cnt = 0;
  rd_exp_t re;
  wb_t     we_e;

  // Monitor: pops expectations whenever the DUT presents a read return or a scrub write-back.
  always @(negedge clk) begin
    if (rst_n) begin
      if (host_rvalid) begin
        if (rd_q.size() == 0) fail_now("rd_unexpected");
        else begin
          re = rd_q.pop_front();
          chk("rd_data", host_rdata, re.d);
          chk("rd_err", host_err, re.e);
          chk("rd_latency", cyc, re.c);
        end
      end
      if (busy && mem_req && mem_we) begin
        if (wb_q.size() == 0) fail_now("wb_unexpected");
        else begin
          we_e = wb_q.pop_front();
          chk("wb_addr", mem_addr, we_e.a);
          chk("wb_code", mem_wdata, we_e.w);
        end
      end
      if (busy && mem_req && !mem_we) begin
        srd_addr.push_back(mem_addr);
        srd_cyc.push_back(cyc);
      end
      if (sweep_done) sdone_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [43:0] d);
    int n = 0;
    nclk();
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    while (!host_gnt && n < 100) begin nclk(); n++; end
    if (!host_gnt) fail_now("wr_grant");
    else chk("wr_code", mem_wdata, enc_f(d));
    nclk();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input logic [43:0] d, input logic e);
    int n = 0;
    nclk();
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    #1;
    while (!host_gnt && n < 100) begin nclk(); n++; end
    if (!host_gnt) fail_now("rd_grant");
    else rd_q.push_back('{d: d, e: e, c: cyc + 2});
    nclk();
    host_req = 1'b0;
  endtask

  task automatic flip(input logic [ADDR_W-1:0] a, input int pos);
    nclk();
    bd_addr = a; bd_flip = '0; bd_flip[pos] = 1'b1; bd_we = 1'b1;
    nclk();
    bd_we = 1'b0;
  endtask

  task automatic pulse_start();
    nclk(); start = 1'b1;
    nclk(); start = 1'b0;
  endtask

  task automatic wait_sweep(input int max);
    int base = sdone_cnt;
    int n = 0;
    while (sdone_cnt == base && n < max) begin nclk(); n++; end
    if (sdone_cnt == base) fail_now("sweep_timeout");
  endtask

  localparam logic [43:0] D0 = 44'h0A5A5A5A5A5;
  localparam logic [43:0] D1 = 44'hFFFFFFFFFFF;
  localparam logic [43:0] D2 = 44'h123456789AB;

  int base_busy, base_log, base_sd, bad, n, run;
  logic g_s[32];
  logic b_s[32];
  logic m_s[32];
  logic exp_g, exp_b;

  initial begin
    // Reset state.
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_sdone", sweep_done, 0);
    repeat (2) nclk();
    rst_n = 1'b1;

    // Host write/read path, including a corrected read.
    host_write(8'd3, D0);
    chk("mem3_code", mem[3], enc_f(D0));
    host_read(8'd3, D0, 1'b0);
    host_write(8'd255, D1);
    host_write(8'd0, D2);
    host_write(8'd200, D1);
    host_read(8'd255, D1, 1'b0);
    host_read(8'd0, D2, 1'b0);
    flip(8'd200, 12);
    host_read(8'd200, D1, 1'b1);
    host_write(8'd200, D1);
    repeat (4) nclk();
    chk("rd_q_drained", rd_q.size(), 0);

    // Burst sweep correcting addr 3.
    flip(8'd3, 7);
    wb_q.push_back('{a: 8'd3, w: enc_f(D0)});
    base_busy = busy_cnt; base_log = srd_addr.size(); base_sd = sdone_cnt;
    pulse_start();
    wait_sweep(2000);
    repeat (3) nclk();
    chk("sweep_busy_cycles", busy_cnt - base_busy, 255 * 2 + 3);
    chk("sweep_reads", srd_addr.size() - base_log, 256);
    bad = 0;
    for (int i = 0; i < 256 && base_log + i < srd_addr.size(); i++)
      if (srd_addr[base_log + i] != 8'(i)) bad++;
    chk("sweep_order", bad, 0);
    chk("sweep_done_pulses", sdone_cnt - base_sd, 1);
    chk("errcnt_one", err_count, 1);
    chk("mem3_fixed", mem[3], enc_f(D0));
    chk("wb_q_drained", wb_q.size(), 0);

    // Saturation: 7 more corrected words on a 3-bit counter.
    for (int a = 10; a <= 16; a++) begin
      flip(8'(a), 5);
      wb_q.push_back('{a: 8'(a), w: '0});
    end
    pulse_start();
    wait_sweep(2000);
    nclk();
    chk("errcnt_saturated", err_count, 3'b111);
    chk("wb_q_sat", wb_q.size(), 0);

    // clr_err coinciding with an increment: clear wins.
    flip(8'd20, 9);
    wb_q.push_back('{a: 8'd20, w: '0});
    pulse_start();
    n = 0;
    while (!(busy && mem_we) && n < 2000) begin nclk(); n++; end
    if (!(busy && mem_we)) fail_now("swb_wait");
    clr_err = 1'b1;
    nclk();
    clr_err = 1'b0;
    chk("clr_beats_inc", err_count, 0);
    wait_sweep(2000);
    chk("errcnt_after_clr", err_count, 0);

    // Periodic scrubbing every SI cycles, full wrap.
    base_log = srd_addr.size(); base_sd = sdone_cnt;
    nclk();
    enable = 1'b1;
    wait_sweep(3000);
    n = 0;
    while (srd_addr.size() < base_log + 257 && n < 20) begin nclk(); n++; end
    enable = 1'b0;
    chk("intv_reads", srd_addr.size() - base_log, 257);
    bad = 0;
    for (int i = 0; i < 257 && base_log + i < srd_addr.size(); i++) begin
      if (srd_addr[base_log + i] != 8'(i % 256)) bad++;
      if (i > 0 && srd_cyc[base_log + i] - srd_cyc[base_log + i - 1] != SI) bad++;
    end
    chk("intv_order_spacing", bad, 0);
    chk("intv_sweep_done", sdone_cnt - base_sd, 1);
    repeat (4) nclk();

    // Starvation: continuous host writes while the interval timer runs.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd50; host_wdata = D2;
    enable = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      g_s[i] = host_gnt; b_s[i] = busy; m_s[i] = mem_req;
      nclk();
    end
    host_req = 1'b0; host_we = 1'b0; enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 28; i++) begin
      exp_g = (i < 24) || (i == 27);
      exp_b = (i == 25) || (i == 26);
      if (g_s[i] != exp_g || b_s[i] != exp_b) bad++;
    end
    chk("starve_pattern", bad, 0);
    run = 0;
    while (run < 32 && g_s[run]) run++;
    chk("starve_grant_run", run, 24);
    chk("starve_win_no_mem", m_s[24], 0);
    repeat (4) nclk();

    // Reset during SCHK of a flagged word.
    flip(8'd30, 9);
    base_log = srd_addr.size();
    pulse_start();
    n = 0;
    while (!(srd_addr.size() > base_log && srd_addr[srd_addr.size() - 1] == 8'd30) && n < 2000) begin
      nclk(); n++;
    end
    if (n >= 2000) fail_now("reach_addr30");
    nclk();
    chk("in_schk_flagged", dec_err, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_outputs", {host_rvalid, host_rdata, host_err, sweep_done, err_count, host_gnt, mem_req}, 0);
    repeat (2) nclk();
    rst_n = 1'b1;
    nclk();
    chk("post_rst_idle", busy, 0);
    chk("mem30_untouched", mem[30], enc_f('0) ^ (105'b1 << 9));
    base_log = srd_addr.size();
    enable = 1'b1;
    n = 0;
    while (srd_addr.size() == base_log && n < 30) begin nclk(); n++; end
    enable = 1'b0;
    if (srd_addr.size() == base_log) fail_now("post_rst_scrub");
    else chk("post_rst_ptr0", srd_addr[base_log], 0);
    repeat (6) nclk();
    chk("final_wb_q", wb_q.size(), 0);
    chk("final_rd_q", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
